// File: rtl/mix_pkg.sv
// Shared types and constants for the mix unit writeback buffer.
// XLEN and TRANS_ID_BITS stand in for the core configuration values.
package mix_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned TRANS_ID_BITS = 3;
    localparam int unsigned MIX_WB_DEPTH  = 2;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic [TRANS_ID_BITS-1:0] trans_id;
        exception_t               exception;
    } mix_wb_entry_t;

endpackage

// File: rtl/mix_wb_fifo.sv
// Storage for mix_wb_buffer: entry array, wrapping pointers, occupancy and flush.
// A push while full is ignored; the top level is responsible for gating it.
module mix_wb_fifo
    import mix_pkg::*;
#(
    parameter int unsigned DEPTH = MIX_WB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  mix_wb_entry_t wdata_i,
    output mix_wb_entry_t rdata_o,
    output logic [CW-1:0] count_o
);

    mix_wb_entry_t mem_q [DEPTH];
    mix_wb_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign push_ok = push_i && (count_q < CW'(DEPTH));
    assign pop_ok  = pop_i && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage is reset too so the head data reads as zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/mix_wb_buffer.sv
// Writeback buffer between the always-ready mix unit and the scoreboard writeback port.
// Optional same-cycle bypass when empty is enabled by defining MIX_WB_BYPASS_EN.
module mix_wb_buffer
    import mix_pkg::*;
#(
    parameter int unsigned DEPTH = MIX_WB_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     fu_valid_i,
    input  logic [XLEN-1:0]          fu_result_i,
    input  logic [TRANS_ID_BITS-1:0] fu_trans_id_i,
    input  exception_t               fu_exception_i,
    output logic                     fu_ready_o,
    output logic                     wb_valid_o,
    output logic [XLEN-1:0]          wb_result_o,
    output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
    output exception_t               wb_exception_o,
    input  logic                     wb_ready_i,
    output logic [CW-1:0]            count_o
);

    mix_wb_entry_t fu_entry, head_entry, out_entry;
    logic [CW-1:0] count;
    logic          empty, push, pop;

    assign fu_entry = '{result: fu_result_i, trans_id: fu_trans_id_i, exception: fu_exception_i};

    assign empty = (count == '0);
    // Ready is a pure function of occupancy: no path from wb_ready_i to issue.
    assign fu_ready_o = (count < CW'(DEPTH));
    assign pop        = ~empty & wb_ready_i;

`ifdef MIX_WB_BYPASS_EN
    logic bypass_take;
    assign bypass_take = empty & fu_valid_i & ~flush_i & wb_ready_i;
    assign push        = fu_valid_i & fu_ready_o & ~flush_i & ~bypass_take;
    assign wb_valid_o  = ~empty | (fu_valid_i & ~flush_i);
    assign out_entry   = empty ? fu_entry : head_entry;
`else
    assign push       = fu_valid_i & fu_ready_o & ~flush_i;
    assign wb_valid_o = ~empty;
    assign out_entry  = head_entry;
`endif

    mix_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (fu_entry),
        .rdata_o (head_entry),
        .count_o (count)
    );

    assign wb_result_o    = out_entry.result;
    assign wb_trans_id_o  = out_entry.trans_id;
    assign wb_exception_o = out_entry.exception;
    assign count_o        = count;

    // The mix unit must never be handed work while the buffer is full.
    a_no_push_when_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(fu_valid_i && !fu_ready_o && !flush_i)
    );

endmodule
